muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer for the EX stage of the pipelined core.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation and runs a 32-step shift-add or restoring-divide loop.
- Returns the 32-bit result after a fixed latency.
- Holds `busy` high meanwhile so hazard control stalls IF/ID/EX; the single-cycle EX-stage arithmetic unit is untouched.

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 142 ++++++++++++++
 tb/tb_muldiv_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX-stage issue logic and the
// iterative multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Operands are reduced to
// magnitudes on acceptance, a 32-step shift-add or restoring-divide loop
// runs on unsigned values, and a two-cycle FIX phase restores signs,
// resolves divide-by-zero and selects the architectural result.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state;
  logic [2:0]        fn;
  logic              neg_a, neg_b, bz;
  logic [CW-1:0]     count;
  // Fixed operand: multiplicand for MUL*, divisor for DIV*/REM*.
  logic [XLEN-1:0]   opnd;
  // MUL*: {product hi, multiplier/product lo}; DIV*: {remainder, quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   fix_res;

  // Operand sign handling at acceptance.
  logic            sa_in, sb_in;
  logic [XLEN-1:0] abs_a, abs_b;
  always_comb begin
    sa_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
            (bus.funct3[2] && !bus.funct3[0]);
    sb_in = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
    abs_a = (sa_in && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    abs_b = (sb_in && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
  end

  // One iteration of shift-add multiply and restoring divide.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nxt;
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd};
    div_ge   = !div_diff[XLEN+1];
    div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                acc[XLEN-2:0], div_ge};
  end

  // Sign correction and result selection. A zero divisor leaves the
  // remainder equal to |op_a|, so the dividend-sign fixup returns op_a.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_sel;
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo  = bz ? '1 : ((neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    rem  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (fn)
      3'b000:                 fix_sel = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_sel = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_sel = quo;
      default:                fix_sel = rem;
    endcase
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fn         <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      bz         <= 1'b0;
      count      <= '0;
      opnd       <= '0;
      acc        <= '0;
      fix_res    <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            fn       <= bus.funct3;
            neg_a    <= sa_in && bus.op_a[XLEN-1];
            neg_b    <= sb_in && bus.op_b[XLEN-1];
            bz       <= (bus.op_b == '0);
            count    <= '0;
            if (bus.funct3[2]) begin
              opnd <= abs_b;
              acc  <= {{XLEN{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              acc  <= {{XLEN{1'b0}}, abs_b};
            end
            state    <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (bus.kill) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc   <= fn[2] ? div_nxt : mul_nxt;
            count <= count + 1'b1;
            if (count == CW'(XLEN-1)) begin
              count <= '0;
              state <= FIX;
            end
          end
        end
        FIX: begin
          // Phase 0 forms the corrected value, phase 1 publishes it.
          if (bus.kill) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (!count[0]) begin
            fix_res <= fix_sel;
            count   <= CW'(1);
          end else begin
            bus.result <= fix_res;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            count      <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results and due cycles are
// queued at acceptance and retired when done pulses.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          last_done = 0;
  int          prev_done = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference for the RV32M ops.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] up;
    logic signed [31:0] x, y;
    sa = {{32{a[31]}}, a};
    x  = a;
    y  = b;
    case (f)
      3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'b001: begin sb = {{32{b[31]}}, b}; sp = sa * sb; return sp[63:32]; end
      3'b010: begin sb = {32'b0, b}; sp = sa * sb; return sp[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return x / y;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return x % y;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Retire scoreboard entries on done; result and latency both checked.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("latency", cyc, mon_e.due);
        last_res = mon_e.res;
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
    if (bus.busy) chk("issue_timeout", 1, 0);
    bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    e.res = exp;
    e.due = cyc + 34;
    sbq.push_back(e);
    // Scramble inputs during RUN; they must not matter.
    bus.start = 1'b0; bus.op_a = ~a; bus.op_b = $urandom; bus.funct3 = ~f;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          nb, dc;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [31:0] picks [5];
    bus.start = 0; bus.kill = 0; bus.funct3 = 0; bus.op_a = 0; bus.op_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    rst_n = 1'b1;

    // MUL 7x6 with busy length and done pulse width.
    issue(3'b000, 32'd7, 32'd6, 32'h2A);
    nb = 0;
    @(negedge clk);
    while (bus.busy && nb < 100) begin nb++; @(negedge clk); end
    chk("busy_len", nb, 34);
    chk("done_high", bus.done, 1);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);

    // Directed signed/unsigned cases, issued back to back.
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    issue(3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
    issue(3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    issue(3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    drain();
    chk("b2b_gap", last_done - prev_done, 35);

    // Kill at RUN count=10.
    issue(3'b000, 32'd123, 32'd456, 32'd0);
    void'(sbq.pop_back());
    dc = done_cnt;
    repeat (10) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    chk("kill_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    chk("kill_no_done", done_cnt, dc);
    chk("kill_result", bus.result, last_res);

    // Reset mid-operation.
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    void'(sbq.pop_back());
    dc = done_cnt;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_result", bus.result, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_no_done", done_cnt, dc);
    issue(3'b010, 32'hFFFF_FFFE, 32'd3, model(3'b010, 32'hFFFF_FFFE, 32'd3));

    // Randomised ops with corner operands mixed in.
    picks[0] = 32'h0; picks[1] = 32'h1; picks[2] = 32'hFFFF_FFFF;
    picks[3] = 32'h8000_0000; picks[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      issue(f, a, b, model(f, a, b));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
